// File: rtl/request_capture_pkg.sv
// -----------------------------------------------------------------------------
// request_capture_pkg
// Shared definitions for the request capture front end of the 8-input
// priority encoder.
//   NUM_REQ      : number of request lines (bit 7 = a = highest priority)
//   state_e      : grant FSM states (IDLE / GRANT)
//   prio_onehot  : one-hot of the highest set bit, MSB first
// -----------------------------------------------------------------------------
package request_capture_pkg;

  localparam int NUM_REQ = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Returns a vector with only the highest-priority (most significant) set
  // bit of req kept; all zero when req is zero.
  function automatic logic [NUM_REQ-1:0] prio_onehot(input logic [NUM_REQ-1:0] req);
    logic [NUM_REQ-1:0] oh;
    logic               found;
    oh    = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && !found) begin
        oh[i] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/sync_edge_8.sv
// -----------------------------------------------------------------------------
// sync_edge_8
// Per-bit multi-flop synchronizer for the raw request lines followed by a
// prev register; produces a one-cycle rise strobe per bit.
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_raw_i   in   raw request lines, asynchronous to clk
//   rise_o     out  rising-edge strobe per bit (sync_out & ~prev)
// Parameter SYNC_STAGES: synchronizer depth, legal range 2..4.
// -----------------------------------------------------------------------------
module sync_edge_8
  import request_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] in_raw_i,
  output logic [NUM_REQ-1:0] rise_o
);

  logic [NUM_REQ-1:0] sync_out;
  logic [NUM_REQ-1:0] prev_q;

  // One register per synchronizer stage; stage 0 samples the raw lines,
  // every later stage samples the one before it.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      logic [NUM_REQ-1:0] stage_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) stage_q <= '0;
          else     stage_q <= in_raw_i;
        end
      end else begin : g_chain
        always_ff @(posedge clk) begin
          if (rst) stage_q <= '0;
          else     stage_q <= g_stage[gi-1].stage_q;
        end
      end
    end
  endgenerate

  assign sync_out = g_stage[SYNC_STAGES-1].stage_q;

  // prev resets to 0, so a line held high through reset release yields
  // exactly one rise event.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= '0;
    else     prev_q <= sync_out;
  end

  assign rise_o = sync_out & ~prev_q;

endmodule

// File: rtl/request_capture_8.sv
// -----------------------------------------------------------------------------
// request_capture_8
// Synchronizes eight raw request lines, captures their rising edges as sticky
// pending bits, and presents one pending request at a time (highest priority
// first) as a one-hot grant on a..h with a valid/ready handshake.
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_raw     in   [7:0] raw request lines (bit 7 = a ... bit 0 = h)
//   a..h       out  granted request, one-hot or all zero
//   out_valid  out  a grant is presented on a..h
//   out_ready  in   consumer accepts the presented grant
//   pending    out  [7:0] sticky pending events
//   overflow   out  sticky: an event arrived on an already-pending bit
// Parameter SYNC_STAGES: synchronizer depth, legal range 2..4.
// -----------------------------------------------------------------------------
module request_capture_8
  import request_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] in_raw,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               e,
  output logic               f,
  output logic               g,
  output logic               h,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] pending,
  output logic               overflow
);

  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] clear;

  state_e             state_q,    state_d;
  logic [NUM_REQ-1:0] grant_q,    grant_d;
  logic [NUM_REQ-1:0] pending_q,  pending_d;
  logic               overflow_q, overflow_d;

  sync_edge_8 #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .in_raw_i (in_raw),
    .rise_o   (rise)
  );

  // Grant FSM. Priority is only evaluated in IDLE, so a higher-priority
  // event arriving during GRANT waits for the current grant to be accepted.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    clear   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          clear   = prio_onehot(pending_q);
          grant_d = clear;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (out_ready) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    // A rise in the same cycle as the clear wins, so an event on the bit
    // being granted right now is kept as a fresh pending event.
    pending_d  = (pending_q & ~clear) | rise;
    overflow_d = overflow_q | (|(rise & pending_q & ~clear));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // grant_q is zero whenever the FSM is in IDLE, so a..h never show a
  // request while out_valid is low.
  assign out_valid = (state_q == ST_GRANT);
  assign {a, b, c, d, e, f, g, h} = grant_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_request_capture_8.sv
module tb_request_capture_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_raw;
  logic       out_ready;
  logic       a, b, c, d, e, f, g, h;
  logic       out_valid;
  logic [7:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  request_capture_8 #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_raw    (in_raw),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .overflow  (overflow)
  );

  wire [7:0] grant_obs = {a, b, c, d, e, f, g, h};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic chk_out(input string tag, input logic exp_valid,
                         input logic [7:0] exp_grant, input logic [7:0] exp_pend);
    chk({tag, ".valid"},   {31'd0, out_valid}, {31'd0, exp_valid});
    chk({tag, ".grant"},   {24'd0, grant_obs}, {24'd0, exp_grant});
    chk({tag, ".pending"}, {24'd0, pending},   {24'd0, exp_pend});
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_raw    = 8'h00;
    out_ready = 1'b0;

    // ---------------- reset ----------------
    repeat (3) tick();
    chk_out("reset", 1'b0, 8'h00, 8'h00);
    chk("reset.overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_out("idle_after_reset", 1'b0, 8'h00, 8'h00);
    end

    // ---------------- single request (bit f) ----------------
    out_ready = 1'b1;
    in_raw = 8'h04;
    tick();                  // edge 0
    tick();                  // edge 1
    in_raw = 8'h00;
    tick();                  // edge 2
    chk_out("single.e2", 1'b0, 8'h00, 8'h04);
    tick();                  // edge 3
    chk_out("single.e3", 1'b1, 8'h04, 8'h00);
    tick();                  // edge 4
    chk_out("single.e4", 1'b0, 8'h00, 8'h00);
    chk("single.overflow", {31'd0, overflow}, 32'd0);
    repeat (4) tick();

    // ---------------- priority a over h ----------------
    in_raw = 8'h81;
    tick();
    tick();
    in_raw = 8'h00;
    tick();                  // edge 2
    chk_out("prio.e2", 1'b0, 8'h00, 8'h81);
    tick();                  // edge 3
    chk_out("prio.e3", 1'b1, 8'h80, 8'h01);
    tick();                  // edge 4: mandatory idle gap
    chk_out("prio.e4", 1'b0, 8'h00, 8'h01);
    tick();                  // edge 5
    chk_out("prio.e5", 1'b1, 8'h01, 8'h00);
    tick();                  // edge 6
    chk_out("prio.e6", 1'b0, 8'h00, 8'h00);
    repeat (4) tick();

    // ---------------- backpressure: c held, a waits ----------------
    out_ready = 1'b0;
    in_raw = 8'h20;
    tick();
    tick();
    in_raw = 8'h00;
    tick();                  // edge 2
    tick();                  // edge 3
    chk_out("bp.e3", 1'b1, 8'h20, 8'h00);
    in_raw = 8'h80;
    for (int k = 4; k <= 8; k++) begin
      tick();
      if (k == 5) in_raw = 8'h00;
      chk("bp.hold.valid", {31'd0, out_valid}, 32'd1);
      chk("bp.hold.grant", {24'd0, grant_obs}, 32'h20);
    end
    chk("bp.pending_a", {24'd0, pending}, 32'h80);
    out_ready = 1'b1;
    tick();                  // edge 9: c accepted
    chk_out("bp.e9", 1'b0, 8'h00, 8'h80);
    tick();                  // edge 10
    chk_out("bp.e10", 1'b1, 8'h80, 8'h00);
    tick();                  // edge 11
    chk_out("bp.e11", 1'b0, 8'h00, 8'h00);
    chk("bp.overflow", {31'd0, overflow}, 32'd0);
    repeat (4) tick();

    // ---------------- overflow on h ----------------
    out_ready = 1'b0;
    in_raw = 8'h81;
    tick();
    tick();
    in_raw = 8'h00;
    tick();                  // edge 2
    tick();                  // edge 3
    chk_out("ovf.e3", 1'b1, 8'h80, 8'h01);
    chk("ovf.e3.overflow", {31'd0, overflow}, 32'd0);
    in_raw = 8'h01;
    tick();                  // edge 4
    tick();                  // edge 5
    in_raw = 8'h00;
    chk("ovf.e5.overflow", {31'd0, overflow}, 32'd0);
    tick();                  // edge 6: second h rise while h pending
    chk("ovf.e6.overflow", {31'd0, overflow}, 32'd1);
    chk_out("ovf.e6", 1'b1, 8'h80, 8'h01);
    tick();
    tick();                  // edge 8
    out_ready = 1'b1;
    tick();                  // edge 9
    chk_out("ovf.e9", 1'b0, 8'h00, 8'h01);
    tick();                  // edge 10
    chk_out("ovf.e10", 1'b1, 8'h01, 8'h00);
    for (int k = 11; k <= 15; k++) begin
      tick();
      chk_out("ovf.no_second_h", 1'b0, 8'h00, 8'h00);
    end
    chk("ovf.sticky", {31'd0, overflow}, 32'd1);

    // ---------------- reset during GRANT ----------------
    out_ready = 1'b0;
    in_raw = 8'hB0;
    tick();
    tick();
    in_raw = 8'h00;
    tick();                  // edge 2
    tick();                  // edge 3
    chk_out("mrst.e3", 1'b1, 8'h80, 8'h30);
    rst = 1'b1;
    tick();
    chk_out("mrst.reset", 1'b0, 8'h00, 8'h00);
    chk("mrst.overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_out("mrst.after", 1'b0, 8'h00, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
